// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// wide (W-bit) or byte (W/2-bit) operands, signed or unsigned.
//   state | meaning
//   IDLE  | waiting for start; operands captured on start
//   LOAD  | operands to magnitudes, divisor checks, count preset
//   ITER  | one radix-2 step per ce cycle, N steps
//   FIX   | sign correction, overflow check, results registered, done pulsed
module muldiv_unit #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         wide,
    input  logic [W-1:0] ta,
    input  logic [W-1:0] tb,
    input  logic [W-1:0] tc,
    output logic [W-1:0] result_lo,
    output logic [W-1:0] result_hi,
    output logic         cy,
    output logic         v,
    output logic         div_error,
    output logic         busy,
    output logic         done
);
    localparam int H  = W / 2;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;
    state_t state, state_nxt;

    logic [1:0]     op_q;
    logic           wide_q, sign_a_q, sign_b_q, err_q;
    logic [2*W-1:0] a_q, acc_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  cnt_q;
    logic           is_div, is_signed;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];

    // Operand conditioning for LOAD
    logic [2*W-1:0] a_ext, mag_a;
    logic [W-1:0]   b_ext, mag_b, r_init, q_init;
    logic           sa, sb, div_zero, div_hi;

    always_comb begin
        if (is_div && wide_q)
            a_ext = a_q;
        else if (is_div || wide_q)
            a_ext = {{W{is_signed & a_q[W-1]}}, a_q[W-1:0]};
        else
            a_ext = {{(2*W-H){is_signed & a_q[H-1]}}, a_q[H-1:0]};
        b_ext    = wide_q ? b_q : {{H{is_signed & b_q[H-1]}}, b_q[H-1:0]};
        sa       = is_signed & a_ext[2*W-1];
        sb       = is_signed & b_ext[W-1];
        mag_a    = sa ? -a_ext : a_ext;
        mag_b    = sb ? -b_ext : b_ext;
        r_init   = wide_q ? mag_a[2*W-1:W] : {{H{1'b0}}, mag_a[W-1:H]};
        q_init   = wide_q ? mag_a[W-1:0]   : {mag_a[H-1:0], {H{1'b0}}};
        div_zero = (mag_b == '0);
        div_hi   = (r_init >= mag_b);
    end

    // Restoring divide step: partial remainder in acc_q upper half, quotient shifts into lower half
    logic [W:0]   r_sh;
    logic [W-1:0] r_sub;
    logic         q_bit;

    always_comb begin
        r_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
        r_sub = r_sh[W-1:0] - b_q;
        q_bit = (r_sh >= {1'b0, b_q});
    end

    // Sign fix-up and flag evaluation for FIX
    logic [2*W-1:0] prod;
    logic [W-1:0]   quot_mag, rem_mag, quot, rem, q_lim;
    logic           neg_q, q_ovf, mul_flag;

    always_comb begin
        neg_q    = sign_a_q ^ sign_b_q;
        prod     = neg_q ? -acc_q : acc_q;
        quot_mag = wide_q ? acc_q[W-1:0] : {{H{1'b0}}, acc_q[H-1:0]};
        rem_mag  = acc_q[2*W-1:W];
        quot     = neg_q ? -quot_mag : quot_mag;
        rem      = sign_a_q ? -rem_mag : rem_mag;
        q_lim    = wide_q ? {1'b1, {(W-1){1'b0}}} : {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};
        q_ovf    = is_signed & (neg_q ? (quot_mag > q_lim) : (quot_mag >= q_lim));
        if (wide_q)
            mul_flag = is_signed ? (prod[2*W-1:W] != {W{prod[W-1]}}) : (prod[2*W-1:W] != '0);
        else
            mul_flag = is_signed ? (prod[W-1:H] != {H{prod[H-1]}}) : (prod[W-1:H] != '0);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (ce)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            // Signed quotient overflow is only reported after iterating, in FIX
            LOAD:    state_nxt = (is_div && (div_zero || (div_hi && !is_signed))) ? FIX : ITER;
            ITER:    if (cnt_q == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = start | (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            case (state)
                IDLE: if (start) begin
                    a_q    <= {tc, ta};
                    b_q    <= tb;
                    op_q   <= op;
                    wide_q <= wide;
                end
                LOAD: begin
                    sign_a_q <= sa;
                    sign_b_q <= sb;
                    b_q      <= mag_b;
                    cnt_q    <= wide_q ? CW'(W-1) : CW'(H-1);
                    err_q    <= is_div & (div_zero | div_hi);
                    if (is_div)
                        acc_q <= {r_init, q_init};
                    else begin
                        acc_q <= '0;
                        a_q   <= mag_a;
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (is_div)
                        acc_q <= {(q_bit ? r_sub : r_sh[W-1:0]), acc_q[W-2:0], q_bit};
                    else begin
                        if (b_q[0]) acc_q <= acc_q + a_q;
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_lo <= '0;
            result_hi <= '0;
            cy        <= 1'b0;
            v         <= 1'b0;
            div_error <= 1'b0;
            done      <= 1'b0;
        end else if (ce) begin
            done <= (state == FIX);
            if (state == FIX) begin
                if (!is_div) begin
                    result_lo <= prod[W-1:0];
                    result_hi <= wide_q ? prod[2*W-1:W] : '0;
                    cy        <= mul_flag;
                    v         <= mul_flag;
                    div_error <= 1'b0;
                end else if (err_q || q_ovf) begin
                    div_error <= 1'b1;
                end else begin
                    result_lo <= wide_q ? quot : {rem[H-1:0], quot[H-1:0]};
                    result_hi <= wide_q ? rem : '0;
                    cy        <= 1'b0;
                    v         <= 1'b0;
                    div_error <= 1'b0;
                end
            end
        end
    end
endmodule
